// File: rtl/bit_encoder.sv
// bit_encoder: sequential 8-to-3 encoder, one set-bit index per valid/ready transfer.
// Optional build macro: BIT_ENCODER_ERR_EN adds err_o (pulses after a zero-vector load).
`default_nettype none

module bit_encoder #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_i,
  input  logic       load_i,
  output logic       busy_o,
  output logic       x_o,
  output logic       y_o,
  output logic       z_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       last_o
`ifdef BIT_ENCODER_ERR_EN
  ,
  output logic       err_o
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] p_q, p_d;
  logic [2:0] code_q, code_d;
  logic       last_q, last_d;
  logic [7:0] p_clr;

  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    // Ascending scan: keep the first hit for LSB-first, the last hit otherwise.
    for (int i = 0; i < 8; i++) begin
      if (v[i] && ((LSB_FIRST == 0) || !found)) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  assign p_clr = p_q & ~(8'd1 << code_q);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    code_d  = code_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (load_i && (d_i != 8'd0)) begin
          state_d = S_EMIT;
          p_d     = d_i;
          code_d  = pick(d_i);
          last_d  = one_hot(d_i);
        end
      end
      S_EMIT: begin
        if (ready_i) begin
          if (last_q) begin
            state_d = S_IDLE;
            p_d     = 8'd0;
            code_d  = 3'd0;
            last_d  = 1'b0;
          end else begin
            p_d    = p_clr;
            code_d = pick(p_clr);
            last_d = one_hot(p_clr);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        p_d     = 8'd0;
        code_d  = 3'd0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= 8'd0;
      code_q  <= 3'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      code_q  <= code_d;
      last_q  <= last_d;
    end
  end

`ifdef BIT_ENCODER_ERR_EN
  logic err_q, err_d;

  assign err_d = (state_q == S_IDLE) && load_i && (d_i == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  assign busy_o  = (state_q == S_EMIT);
  assign valid_o = (state_q == S_EMIT);
  assign x_o     = code_q[2];
  assign y_o     = code_q[1];
  assign z_o     = code_q[0];
  assign last_o  = last_q;

endmodule

`default_nettype wire
